spi_master: RTL
===============

Name: spi_master

Overview:
SPI initiator that drives the on-board SPI responder (7-bit address plus R/W header, 8-bit data frame) from a system-clock domain. It sits between a local command interface (start/addr/rw/wdata) and the four SPI pins. It generates sclk, cs_n and mosi, samples miso, and returns read data with a one-cycle done pulse. Frame: 16 bits, MSB first: addr[6:0], rw, then 8 data bits.

Parameters:
HALF_PERIOD, 4, number of clk cycles per sclk half-period (legal values ≥1); this also sets the cs_n setup, hold and idle gap.

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a transaction; sampled only in IDLE
addr  input  7  responder register address; latched at start
rw  input  1  1 = write, 0 = read; latched at start
wdata  input  8  write data; latched at start
busy  output  1  high from the cycle after start acceptance until return to IDLE
done  output  1  one-cycle pulse at transaction end
rdata  output  8  data captured during the data phase of a read
sclk  output  1  SPI clock; idles low
cs_n  output  1  chip select, active low
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (async assert, sync release): state=IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=0. Reset during a transfer aborts it immediately, with no done pulse.
- Tick generator: a counter counts 0..HALF_PERIOD-1 and emits a tick on its terminal count. It is cleared on start acceptance and is active only outside IDLE.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE: on start=1, latch tx_sr = {addr, rw, rw ? wdata : 8'h00} and go to SETUP. In the same edge set cs_n=0, mosi=tx_sr[15], busy=1, bit_cnt=0.
- SETUP: on tick, set sclk=1 (rising edge 1) and go to XFER.
- XFER: on each tick, toggle sclk.
  - Tick where sclk goes 1→0: shift miso into rx_sr[7:0] (LSB in) and increment bit_cnt. If bit_cnt was 15, go to HOLD with sclk=0; otherwise shift tx_sr left and set mosi to the new MSB.
  - Tick where sclk goes 0→1: no data action.
- HOLD: on tick, set cs_n=1 and mosi=0 and pulse done for this one cycle. If the latched rw=0, load rdata=rx_sr; on writes rdata holds its previous value. Go to GAP.
- GAP: on tick, set busy=0 and go to IDLE. A start asserted in the same cycle busy falls is ignored; start is accepted from the next cycle.
- Timing, with t0 = the start-accept edge:
  - sclk rising edges occur at t0+(2k+1)·HALF_PERIOD for k=0..15.
  - done asserts at t0+33·HALF_PERIOD.
  - busy falls at t0+34·HALF_PERIOD.
  - Exactly 16 sclk rising edges per frame.
- Data/edge rules: mosi changes only on sclk falling-edge ticks or at cs_n assertion, so it is stable at every rising edge. miso is sampled at the end of each high phase.
- start while busy=1 is ignored. Changes to addr, rw or wdata after acceptance are ignored.
- miso value outside the data phase is irrelevant; the address-phase miso samples are shifted out of rx_sr and never reach rdata.

Decomposition:
- Shared package spi_pkg:
  - Constants: SPI_ADDR_BITS=7, SPI_DATA_BITS=8, SPI_FRAME_BITS=16, SPI_RW_WRITE=1'b1, SPI_RW_READ=1'b0.
  - State encoding for IDLE, SETUP, XFER, HOLD, GAP.
- One sub-module: spi_tick_gen, holding the HALF_PERIOD counter with clear and enable, output tick.

Test Plan:
1. Reset check, HALF_PERIOD=2: assert rst_n=0 -> sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=0.
2. Write, HALF_PERIOD=2, addr=7'h2A, rw=1, wdata=8'hC3 -> mosi at the 16 rising edges is 0101010_1_11000011; done at t0+66; busy low at t0+68; rdata unchanged.
3. Read, addr=7'h15, rw=0, responder model drives 8'hA5 MSB-first during bits 8..15 -> mosi header 0010101_0, data bits all 0; rdata=8'hA5 in the done cycle.
4. Back-to-back: start held high continuously -> second frame accepted one cycle after busy falls; cs_n high ≥HALF_PERIOD cycles between frames; start pulses during busy produce no extra frame.
5. Abort: assert rst_n=0 after the 5th sclk rise of a read -> same cycle cs_n=1, sclk=0, busy=0, no done; next write completes correctly.
6. HALF_PERIOD=1 write of addr=7'h7F, wdata=8'hFF -> 16 rises at odd offsets t0+1..t0+31; done at t0+33; busy low at t0+34.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI initiator.
// Frame layout: addr[6:0], rw, data[7:0], sent MSB first.
package spi_pkg;

  localparam int unsigned SPI_ADDR_BITS  = 7;
  localparam int unsigned SPI_DATA_BITS  = 8;
  localparam int unsigned SPI_FRAME_BITS = 16;

  localparam logic SPI_RW_WRITE = 1'b1;
  localparam logic SPI_RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StGap
  } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timebase: counts 0..HALF_PERIOD-1 while enabled and flags the terminal count.
// Clearing restarts the count so the first tick lands exactly HALF_PERIOD cycles later.
module spi_tick_gen #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(HALF_PERIOD - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = enable && (cnt_q == TermCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI initiator for a 7-bit address + R/W header and 8-bit data frame (mode 0, MSB first).
// All pin outputs are registered; done is a single-cycle pulse at the end of the frame.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SPI_ADDR_BITS-1:0] addr,
  input  logic                     rw,
  input  logic [SPI_DATA_BITS-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic [SPI_DATA_BITS-1:0] rdata,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     mosi,
  input  logic                     miso
);

  localparam int unsigned BitCntW = $clog2(SPI_FRAME_BITS);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(SPI_FRAME_BITS - 1);

  spi_state_e                  state;
  logic [SPI_FRAME_BITS-1:0]   tx_sr;
  logic [SPI_DATA_BITS-1:0]    rx_sr;
  logic [BitCntW-1:0]          bit_cnt;
  logic                        rw_q;
  logic                        accept;
  logic                        tick;
  logic [SPI_FRAME_BITS-1:0]   frame;

  assign accept = (state == StIdle) && start;
  // Reads send zeros in the data phase regardless of wdata.
  assign frame  = {addr, rw, (rw == SPI_RW_WRITE) ? wdata : {SPI_DATA_BITS{1'b0}}};

  spi_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .enable(state != StIdle),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rw_q    <= SPI_RW_READ;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            tx_sr   <= frame;
            rw_q    <= rw;
            cs_n    <= 1'b0;
            mosi    <= frame[SPI_FRAME_BITS-1];
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= StSetup;
          end
        end
        StSetup: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= StXfer;
          end
        end
        StXfer: begin
          if (tick) begin
            if (sclk) begin
              // Falling edge: sample at the end of the high phase, then advance mosi.
              sclk    <= 1'b0;
              rx_sr   <= {rx_sr[SPI_DATA_BITS-2:0], miso};
              bit_cnt <= bit_cnt + BitCntW'(1);
              if (bit_cnt == LastBit) begin
                state <= StHold;
              end else begin
                tx_sr <= {tx_sr[SPI_FRAME_BITS-2:0], 1'b0};
                mosi  <= tx_sr[SPI_FRAME_BITS-2];
              end
            end else begin
              sclk <= 1'b1;
            end
          end
        end
        StHold: begin
          if (tick) begin
            cs_n <= 1'b1;
            mosi <= 1'b0;
            done <= 1'b1;
            if (rw_q == SPI_RW_READ) begin
              rdata <= rx_sr;
            end
            state <= StGap;
          end
        end
        StGap: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
